// File: rtl/inv_bist_pkg.sv
// ---------------------------------------------------------------------------
// inv_bist_pkg
// Shared definitions for the inverter-bank BIST sequencer:
//   - state_t      : sequencer state encoding (IDLE=0, DRV=1, CHK=2, DONE=3)
//   - pattern_f    : stimulus pattern for a 2-bit phase index
//   - popcount_f   : number of set bits in a mismatch vector
//   - err_w_f      : width of the saturating mismatch counter for N cells
// Vectors passed through the helpers are MAX_CELLS wide; callers size-cast
// to/from their own N_CELLS width, so N_CELLS must not exceed MAX_CELLS.
// ---------------------------------------------------------------------------
package inv_bist_pkg;

    localparam int MAX_CELLS = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRV  = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Phase 0: all-0, 1: all-1, 2: ALT (bit i = i[0]), 3: ~ALT.
    function automatic logic [MAX_CELLS-1:0] pattern_f(input logic [1:0] ph);
        logic [MAX_CELLS-1:0] alt;
        for (int i = 0; i < MAX_CELLS; i++) begin
            alt[i] = i[0];
        end
        case (ph)
            2'd0:    return '0;
            2'd1:    return '1;
            2'd2:    return alt;
            default: return ~alt;
        endcase
    endfunction

    function automatic logic [6:0] popcount_f(input logic [MAX_CELLS-1:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_CELLS; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

    // Four phases of N cells can mismatch at most 4*N bits in one run.
    function automatic int err_w_f(input int n);
        return $clog2(4 * n + 1);
    endfunction

endpackage

// File: rtl/inv_bist_ctrl_if.sv
// ---------------------------------------------------------------------------
// inv_bist_ctrl_if
// Bundles the BIST control, bank and result signals.
//   start, abort        : run control from test/config logic
//   stim  [N_CELLS]     : registered drive to the inverter inputs
//   resp  [N_CELLS]     : inverter outputs back to the sequencer
//   busy, done, pass    : run status
//   fail_map [N_CELLS]  : sticky per-cell mismatch flags
//   err_count [ERR_W]   : saturating mismatched-bit count
// slave  : the sequencer side; master : the stimulus/bank side.
// ---------------------------------------------------------------------------
interface inv_bist_ctrl_if #(
    parameter int N_CELLS = 8
);
    import inv_bist_pkg::*;

    localparam int ERR_W = err_w_f(N_CELLS);

    logic               start;
    logic               abort;
    logic [N_CELLS-1:0] stim;
    logic [N_CELLS-1:0] resp;
    logic               busy;
    logic               done;
    logic               pass;
    logic [N_CELLS-1:0] fail_map;
    logic [ERR_W-1:0]   err_count;

    modport slave (
        input  start, abort, resp,
        output stim, busy, done, pass, fail_map, err_count
    );

    modport master (
        output start, abort, resp,
        input  stim, busy, done, pass, fail_map, err_count
    );

endinterface

// File: rtl/inv_settle_timer.sv
// ---------------------------------------------------------------------------
// inv_settle_timer
// Loadable down-counter that times the stimulus settle window.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_load       : load i_load_val (wins over counting)
//   i_load_val   : value loaded; expiry follows i_load_val+1 cycles later
//   i_en         : decrement while non-zero
//   o_expire     : counter has reached zero
// ---------------------------------------------------------------------------
module inv_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/inv_bist_ctrl.sv
// ---------------------------------------------------------------------------
// inv_bist_ctrl
// BIST sequencer for a bank of N_CELLS inverters. Each run steps through four
// patterns (all-0, all-1, ALT, ~ALT); each pattern is held SETTLE_CYC cycles,
// then the bank response is compared against the inverted stimulus for one
// cycle. Mismatches accumulate into a sticky per-cell map and a saturating
// bit count; pass reports a clean run.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : inv_bist_ctrl_if.slave (start/abort in, stim out, resp in,
//            busy/done/pass/fail_map/err_count out)
// ---------------------------------------------------------------------------
module inv_bist_ctrl
    import inv_bist_pkg::*;
#(
    parameter int N_CELLS    = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    inv_bist_ctrl_if.slave  bus
);

    localparam int ERR_W = err_w_f(N_CELLS);
    localparam int SUM_W = ERR_W + 1;
    localparam int TMR_W = $clog2(SETTLE_CYC + 1);

    // Adds a popcount into the running total, clamping at all-ones.
    function automatic logic [ERR_W-1:0] sat_add_f(input logic [ERR_W-1:0] a,
                                                   input logic [6:0]       b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return s[ERR_W] ? '1 : s[ERR_W-1:0];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_phase;
    logic [N_CELLS-1:0] r_stim;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [N_CELLS-1:0] r_fail_map;
    logic [ERR_W-1:0]   r_err;

    logic               w_accept;
    logic               w_abort;
    logic               w_acc;
    logic               w_finish;
    logic               w_adv;
    logic               w_leave;
    logic               w_load;
    logic               w_expire;
    logic [N_CELLS-1:0] w_mism;
    logic [N_CELLS-1:0] w_fm_nxt;
    logic [ERR_W-1:0]   w_err_nxt;
    logic [N_CELLS-1:0] w_pat_first;
    logic [N_CELLS-1:0] w_pat_next;

    // Load SETTLE_CYC-1 so the counter reads zero in the last DRV cycle,
    // giving exactly SETTLE_CYC DRV cycles per phase.
    inv_settle_timer #(
        .W (TMR_W)
    ) u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (TMR_W'(SETTLE_CYC - 1)),
        .i_en       (r_state == ST_DRV),
        .o_expire   (w_expire)
    );

    // An ideal inverter returns ~stim; any set bit here is a faulty cell.
    assign w_mism      = bus.resp ^ ~r_stim;
    assign w_fm_nxt    = r_fail_map | w_mism;
    assign w_err_nxt   = sat_add_f(r_err, popcount_f(MAX_CELLS'(w_mism)));
    assign w_pat_first = N_CELLS'(pattern_f(2'd0));
    assign w_pat_next  = N_CELLS'(pattern_f(r_phase + 2'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_acc       = 1'b0;
        w_finish    = 1'b0;
        w_adv       = 1'b0;
        w_leave     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // abort is meaningless here, so start always wins.
                if (bus.start) begin
                    w_state_nxt = ST_DRV;
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                end
            end
            ST_DRV: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else if (w_expire) begin
                    w_state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                // An abort here discards this phase's compare.
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_acc = 1'b1;
                    if (r_phase == 2'd3) begin
                        w_state_nxt = ST_DONE;
                        w_finish    = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRV;
                        w_adv       = 1'b1;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_leave     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // busy drops and done/pass are set on the edge entering DONE, so done
    // and the final verdict are visible together for the single DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_stim     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_map <= '0;
            r_err      <= '0;
        end else if (w_accept) begin
            r_phase    <= '0;
            r_stim     <= w_pat_first;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_fail_map <= '0;
            r_err      <= '0;
        end else if (w_abort) begin
            r_stim <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_acc) begin
            r_fail_map <= w_fm_nxt;
            r_err      <= w_err_nxt;
            if (w_finish) begin
                r_stim <= '0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_fm_nxt == '0) && (w_err_nxt == '0);
            end else if (w_adv) begin
                r_phase <= r_phase + 2'd1;
                r_stim  <= w_pat_next;
            end
        end else if (w_leave) begin
            r_done <= 1'b0;
        end
    end

    assign bus.stim      = r_stim;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_map  = r_fail_map;
    assign bus.err_count = r_err;

endmodule

// File: tb/tb_inv_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inv_bist_ctrl
// Bench for inv_bist_ctrl with a modelled inverter bank (stuck-at masks,
// buffer mode, and junk on resp outside compare cycles).
// ---------------------------------------------------------------------------
module tb_inv_bist_ctrl;

    localparam int N      = 8;
    localparam int S      = 2;
    localparam int L      = S + 1;          // cycles per phase
    localparam int DONE_C = 4 * L + 1;      // done cycle after start accept
    localparam int ERR_W  = $clog2(4 * N + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    inv_bist_ctrl_if #(.N_CELLS(N)) bus ();

    inv_bist_ctrl #(
        .N_CELLS    (N),
        .SETTLE_CYC (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [N-1:0] sa0   = '0;
    logic [N-1:0] sa1   = '0;
    logic [N-1:0] junk  = '0;
    logic         buf_m = 1'b0;

    assign bus.resp = (buf_m ? bus.stim : ((~bus.stim & ~sa0) | sa1)) ^ junk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] pat(input int p);
        logic [N-1:0] alt;
        for (int i = 0; i < N; i++) alt[i] = (i % 2 == 1);
        case (p)
            0:       return '0;
            1:       return '1;
            2:       return alt;
            default: return ~alt;
        endcase
    endfunction

    // What a faulty bank would return for a clean pattern, compared with ~d.
    function automatic logic [N-1:0] phase_mism(input int p);
        logic [N-1:0] d, r;
        d = pat(p);
        r = buf_m ? d : ((~d & ~sa0) | sa1);
        return r ^ ~d;
    endfunction

    function automatic int ones(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic check_all(input string tag, input logic [N-1:0] e_stim, input bit e_busy,
                             input bit e_done, input bit e_pass, input logic [N-1:0] e_fm,
                             input int e_err);
        check({tag, " stim"},     32'(bus.stim),      32'(e_stim));
        check({tag, " busy"},     32'(bus.busy),      32'(e_busy));
        check({tag, " done"},     32'(bus.done),      32'(e_done));
        check({tag, " pass"},     32'(bus.pass),      32'(e_pass));
        check({tag, " fail_map"}, 32'(bus.fail_map),  32'(e_fm));
        check({tag, " err"},      32'(bus.err_count), 32'(e_err));
    endtask

    // One run: start accepted at cycle 0; optional abort in cycle abort_c and
    // start re-pulse in cycle restart_c (0 = none). Every cycle up to a few
    // past done is checked against the phase-level model.
    task automatic run(input string name, input logic [N-1:0] sa0_i, input logic [N-1:0] sa1_i,
                       input bit buf_i, input int abort_c, input int restart_c,
                       input bit abort_with_start, input bit junk_en);
        bit           aborted, total_zero;
        logic [N-1:0] e_fm, e_stim;
        int           e_err, max_err;
        sa0   = sa0_i;
        sa1   = sa1_i;
        buf_m = buf_i;
        max_err = (1 << ERR_W) - 1;
        total_zero = 1'b1;
        for (int p = 0; p < 4; p++) if (phase_mism(p) != '0) total_zero = 1'b0;
        bus.start = 1'b1;
        bus.abort = abort_with_start;
        junk      = junk_en ? N'($urandom) : '0;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 1; c <= DONE_C + 3; c++) begin
            aborted = (abort_c != 0) && (c > abort_c);
            e_fm  = '0;
            e_err = 0;
            for (int p = 0; p < 4; p++) begin
                if ((c >= L * p + L + 1) && (abort_c == 0 || (L * p + L) < abort_c)) begin
                    e_fm  |= phase_mism(p);
                    e_err += ones(phase_mism(p));
                end
            end
            if (e_err > max_err) e_err = max_err;
            e_stim = (!aborted && c <= 4 * L) ? pat((c - 1) / L) : '0;
            check_all($sformatf("%s c%0d", name, c), e_stim,
                      !aborted && c <= 4 * L,
                      !aborted && c == DONE_C,
                      !aborted && c >= DONE_C && total_zero,
                      e_fm, e_err);
            bus.start = (c == restart_c);
            bus.abort = (c == abort_c);
            junk = (junk_en && !(c <= 4 * L && c % L == 0)) ? N'($urandom) : '0;
            tick();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        junk      = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check_all("reset", '0, 1'b0, 1'b0, 1'b0, '0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed scenarios.
        run("ideal",     8'h00, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0);
        bus.abort = 1'b1;
        tick();
        tick();
        bus.abort = 1'b0;
        check_all("idle_abort", '0, 1'b0, 1'b0, 1'b1, '0, 0);
        run("sa0_c3",    8'h08, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0);
        run("buffer",    8'h00, 8'h00, 1'b1, 0, 0, 1'b0, 1'b0);
        run("restart",   8'h00, 8'h00, 1'b0, 0, 4, 1'b0, 1'b0);
        run("restart_d", 8'h00, 8'h00, 1'b0, 0, DONE_C, 1'b0, 1'b0);
        run("abort_chk", 8'h08, 8'h00, 1'b0, 3 * L, 0, 1'b0, 1'b0);
        run("st_and_ab", 8'h00, 8'h00, 1'b0, 0, 0, 1'b1, 1'b1);

        // Asynchronous reset mid-DRV of phase 1.
        sa0 = 8'h08;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check_all("pre_rst", 8'hFF, 1'b1, 1'b0, 1'b0, 8'h08, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", '0, 1'b0, 1'b0, 1'b0, '0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst",  8'h00, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0);

        // Randomized runs.
        for (int k = 0; k < 24; k++) begin
            logic [N-1:0] s0, s1;
            bit           b;
            int           a, r;
            s0 = N'($urandom & $urandom);
            s1 = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) s0 = '0;
            if ($urandom_range(0, 3) == 0) s1 = '0;
            b = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DONE_C)) : 0;
            r = 0;
            if ($urandom_range(0, 2) == 0) r = int'($urandom_range(1, (a != 0) ? a : DONE_C));
            run($sformatf("rnd%0d", k), s0, s1, b, a, r, 1'(($urandom_range(0, 3) == 0)), 1'b1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inv_bist_ctrl.md
Name: inv_bist_ctrl

Overview:
- Built-in self-test sequencer for a bank of N_CELLS Cmos_inverter instances.
- Drives stimulus onto every cell input, waits a settle window, compares each cell output against the inverted stimulus, and accumulates per-cell fault flags and a mismatch count.
- Sits between the test/config logic (start/abort) and the inverter bank (stim out, resp in).

Parameters:
N_CELLS, 8, number of inverter cells under test (>=1)
SETTLE_CYC, 2, clock cycles stim is held before the compare cycle (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a test run; sampled only in IDLE
abort  input  1  terminate the current run; highest priority after reset
stim  output  N_CELLS  registered drive to cell inputs
resp  input  N_CELLS  cell outputs
busy  output  1  high from the cycle after start is accepted until DONE is entered
done  output  1  one-cycle pulse when a run completes; never pulses on abort
pass  output  1  1 when the last completed run had zero mismatches
fail_map  output  N_CELLS  sticky per-cell mismatch flags
err_count  output  $clog2(4*N_CELLS+1)  total mismatched bits in the run, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE, stim=0, busy=0, done=0, pass=0, fail_map=0, err_count=0.
- States: IDLE, DRV, CHK, DONE. A 2-bit phase index selects the pattern:
  - 0 = all-0
  - 1 = all-1
  - 2 = ALT (bit i = i[0]; 0xAA for N=8)
  - 3 = ~ALT (0x55)
- IDLE:
  - start=1 at an edge moves to DRV, phase=0, stim<=pattern(0), busy<=1.
  - The same edge clears fail_map, err_count and pass.
- DRV: stim is held. Stay exactly SETTLE_CYC cycles (settle counter), then go to CHK.
- CHK: one cycle. mism = resp ^ ~stim.
  - fail_map <= fail_map | mism.
  - err_count <= err_count + popcount(mism), saturating at all-ones.
  - phase<3: phase++, stim<=pattern(phase+1), go to DRV.
  - phase==3: go to DONE.
- DONE: one cycle.
  - done=1; pass=1 iff err_count==0 and fail_map==0 (computed from the final values).
  - busy<=0, stim<=0, then go to IDLE.
- Latency: the start-accept edge is cycle 0. done is high during cycle 4*(SETTLE_CYC+1)+1, which is cycle 13 at the defaults.
- start while not in IDLE, including during DONE: ignored, no queuing.
- abort=1 in DRV/CHK/DONE:
  - Next edge goes to IDLE with stim=0, busy=0, done=0, pass=0.
  - fail_map and err_count hold their partial values.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, start wins.
- Results (pass, fail_map, err_count) hold until the next accepted start or reset.
- The compare uses resp as sampled in the CHK cycle only. resp in DRV cycles is ignored.

Decomposition:
- Package inv_bist_pkg holds:
  - state encoding localparams (IDLE=0, DRV=1, CHK=2, DONE=3)
  - phase pattern selector function
  - popcount function
  - err_count width function
- One sub-module, inv_settle_timer: loadable down-counter of width $clog2(SETTLE_CYC+1), with load and expire outputs, reset by rst_n.

Test Plan:
1. Bank of 8 ideal inverters, SETTLE_CYC=2, start pulse -> stim sequence 0x00, 0xFF, 0xAA, 0x55; done at cycle 13; pass=1, fail_map=0x00, err_count=0; busy high cycles 1-12.
2. Cell 3 stuck-at-0 (resp[3]=0) -> mismatches in phases 0 (0x00) and 3 (0x55) -> fail_map=0x08, err_count=2, pass=0.
3. All cells wired as buffers (resp=stim) -> every bit mismatches in all 4 phases -> fail_map=0xFF, err_count=32, pass=0.
4. start re-pulsed in DRV of phase 1 -> ignored; done still at cycle 13; results match scenario 1.
5. abort asserted in CHK of phase 2 with cell 3 stuck-at-0 -> IDLE next edge, stim=0, done never pulses, pass=0, fail_map=0x08, err_count=1.
6. rst_n low mid-DRV of phase 1 -> all outputs 0 immediately (async, no clock edge); after release a new start runs a clean 13-cycle test.
